ps2_key_decoder: RTL and testbench

- Sits directly downstream of the PS/2 byte receiver and consumes its scancode/new_code strobe.
- Assembles Set-2 byte sequences (E0 extended prefix, F0 break prefix, E1 Pause sequence) into single key events.
- Tracks shift/ctrl/caps state and attaches an ASCII translation to each event.
- Buffers events in a small ready/valid FIFO for the game/UI logic.

---
 rtl/ps2_pkg.sv | 68 ++++++
 rtl/ps2_key_decoder_ascii_map.sv | 119 +++++++++++
 rtl/ps2_key_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared constants, event field layout and decoder state
//                encoding for the PS/2 Set-2 key decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Set-2 protocol bytes
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;

    // Modifier key codes
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CTRL   = 8'h14;
    localparam logic [7:0] PS2_CAPS   = 8'h58;

    // Bytes that follow the E1 prefix of the Pause sequence
    localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

    // Event word layout: {released, extended, shift, ctrl, ascii[7:0], code[7:0]}
    localparam int EV_WIDTH     = 20;
    localparam int EV_CODE_LSB  = 0;
    localparam int EV_ASCII_LSB = 8;
    localparam int EV_CTRL_BIT  = 16;
    localparam int EV_SHIFT_BIT = 17;
    localparam int EV_EXT_BIT   = 18;
    localparam int EV_REL_BIT   = 19;

    // Byte-sequence assembler states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } ps2_state_t;

    // Keyboard status/acknowledge bytes that never form a key event
    function automatic logic ps2_is_status(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    function automatic logic [EV_WIDTH-1:0] ps2_pack_event(
        input logic       released,
        input logic       extended,
        input logic       shift,
        input logic       ctrl,
        input logic [7:0] ascii,
        input logic [7:0] code
    );
        logic [EV_WIDTH-1:0] ev;
        ev = '0;
        ev[EV_REL_BIT]                  = released;
        ev[EV_EXT_BIT]                  = extended;
        ev[EV_SHIFT_BIT]                = shift;
        ev[EV_CTRL_BIT]                 = ctrl;
        ev[EV_ASCII_LSB +: 8]           = ascii;
        ev[EV_CODE_LSB +: 8]            = code;
        return ev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_decoder_ascii_map.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_ascii_map
//  Description : Combinational Set-2 scancode to ASCII translation with
//                shift / caps-lock handling. Extended codes map to 00.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_ascii_map (
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic       w_is_letter;
    logic [4:0] w_letter_idx;
    logic       w_is_digit;
    logic [3:0] w_digit_idx;
    logic [7:0] w_special;
    logic [7:0] w_digit_sym;

    // Classify the code as letter (index a..z), digit (0..9) or special key
    always_comb begin
        w_is_letter  = 1'b1;
        w_letter_idx = 5'd0;
        w_is_digit   = 1'b0;
        w_digit_idx  = 4'd0;
        w_special    = 8'h00;
        case (code)
            8'h1C: w_letter_idx = 5'd0;
            8'h32: w_letter_idx = 5'd1;
            8'h21: w_letter_idx = 5'd2;
            8'h23: w_letter_idx = 5'd3;
            8'h24: w_letter_idx = 5'd4;
            8'h2B: w_letter_idx = 5'd5;
            8'h34: w_letter_idx = 5'd6;
            8'h33: w_letter_idx = 5'd7;
            8'h43: w_letter_idx = 5'd8;
            8'h3B: w_letter_idx = 5'd9;
            8'h42: w_letter_idx = 5'd10;
            8'h4B: w_letter_idx = 5'd11;
            8'h3A: w_letter_idx = 5'd12;
            8'h31: w_letter_idx = 5'd13;
            8'h44: w_letter_idx = 5'd14;
            8'h4D: w_letter_idx = 5'd15;
            8'h15: w_letter_idx = 5'd16;
            8'h2D: w_letter_idx = 5'd17;
            8'h1B: w_letter_idx = 5'd18;
            8'h2C: w_letter_idx = 5'd19;
            8'h3C: w_letter_idx = 5'd20;
            8'h2A: w_letter_idx = 5'd21;
            8'h1D: w_letter_idx = 5'd22;
            8'h22: w_letter_idx = 5'd23;
            8'h35: w_letter_idx = 5'd24;
            8'h1A: w_letter_idx = 5'd25;
            default: begin
                w_is_letter = 1'b0;
                w_is_digit  = 1'b1;
                case (code)
                    8'h45: w_digit_idx = 4'd0;
                    8'h16: w_digit_idx = 4'd1;
                    8'h1E: w_digit_idx = 4'd2;
                    8'h26: w_digit_idx = 4'd3;
                    8'h25: w_digit_idx = 4'd4;
                    8'h2E: w_digit_idx = 4'd5;
                    8'h36: w_digit_idx = 4'd6;
                    8'h3D: w_digit_idx = 4'd7;
                    8'h3E: w_digit_idx = 4'd8;
                    8'h46: w_digit_idx = 4'd9;
                    default: begin
                        w_is_digit = 1'b0;
                        case (code)
                            8'h29:   w_special = 8'h20;
                            8'h5A:   w_special = 8'h0D;
                            8'h66:   w_special = 8'h08;
                            8'h76:   w_special = 8'h1B;
                            default: w_special = 8'h00;
                        endcase
                    end
                endcase
            end
        endcase
    end

    // Shifted symbols on the digit row (US layout)
    always_comb begin
        w_digit_sym = 8'h00;
        case (w_digit_idx)
            4'd0:    w_digit_sym = 8'h29;  // )
            4'd1:    w_digit_sym = 8'h21;  // !
            4'd2:    w_digit_sym = 8'h40;  // @
            4'd3:    w_digit_sym = 8'h23;  // #
            4'd4:    w_digit_sym = 8'h24;  // $
            4'd5:    w_digit_sym = 8'h25;  // %
            4'd6:    w_digit_sym = 8'h5E;  // ^
            4'd7:    w_digit_sym = 8'h26;  // &
            4'd8:    w_digit_sym = 8'h2A;  // *
            4'd9:    w_digit_sym = 8'h28;  // (
            default: w_digit_sym = 8'h00;
        endcase
    end

    // Final selection; caps-lock only affects letters
    always_comb begin
        ascii = 8'h00;
        if (ext) begin
            ascii = 8'h00;
        end else if (w_is_letter) begin
            ascii = ((shift ^ caps) ? 8'h41 : 8'h61) + {3'b000, w_letter_idx};
        end else if (w_is_digit) begin
            ascii = shift ? w_digit_sym : (8'h30 + {4'b0000, w_digit_idx});
        end else begin
            ascii = w_special;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_decoder
//  Description : Assembles PS/2 Set-2 byte sequences into key events, tracks
//                shift/ctrl/caps state, attaches ASCII and queues events in a
//                ready/valid FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          scancode,
    input  logic                new_code,
    output logic [EV_WIDTH-1:0] ev_data,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic                overflow,
    output logic                caps_lock
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // Sequence assembler state
    // ------------------------------------------------------------------
    ps2_state_t r_state, w_state_next;
    logic [2:0] r_skip_cnt, w_skip_next;

    logic       w_emit;
    logic       w_released;
    logic       w_ext;
    logic [7:0] w_code;

    // Modifier state
    logic r_lshift, r_rshift, r_ctrl, r_caps, r_caps_held;
    logic w_lshift_next, w_rshift_next, w_ctrl_next, w_caps_next, w_caps_held_next;
    logic w_shift_next;

    logic [7:0]          w_ascii;
    logic [EV_WIDTH-1:0] w_event;

    // FIFO
    logic [EV_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]         r_wr_ptr, r_rd_ptr;
    logic                r_overflow;
    logic                w_empty, w_full, w_pop, w_push, w_drop;

    // State register for the byte-sequence assembler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_next;
            r_skip_cnt <= w_skip_next;
        end
    end

    // Next-state and event decode, one step per received byte
    always_comb begin
        w_state_next = r_state;
        w_skip_next  = r_skip_cnt;
        w_emit       = 1'b0;
        w_released   = 1'b0;
        w_ext        = 1'b0;
        w_code       = scancode;
        if (new_code) begin
            case (r_state)
                ST_IDLE: begin
                    if (scancode == PS2_EXT) begin
                        w_state_next = ST_EXT;
                    end else if (scancode == PS2_BRK) begin
                        w_state_next = ST_BRK;
                    end else if (scancode == PS2_PAUSE) begin
                        w_state_next = ST_SKIP;
                        w_skip_next  = PAUSE_SKIP_LEN;
                    end else if (!ps2_is_status(scancode)) begin
                        w_emit = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (scancode == PS2_BRK) begin
                        w_state_next = ST_EXT_BRK;
                    end else if (scancode != PS2_EXT) begin
                        w_emit       = 1'b1;
                        w_ext        = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (scancode == PS2_EXT) begin
                        // Malformed F0 E0: treat as the start of an extended code
                        w_state_next = ST_EXT;
                    end else if (scancode != PS2_BRK) begin
                        w_emit       = 1'b1;
                        w_released   = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    w_state_next = ST_IDLE;
                    if ((scancode != PS2_EXT) && (scancode != PS2_BRK)) begin
                        w_emit     = 1'b1;
                        w_released = 1'b1;
                        w_ext      = 1'b1;
                    end
                end
                ST_SKIP: begin
                    w_skip_next = r_skip_cnt - 3'd1;
                    if (r_skip_cnt <= 3'd1) begin
                        // Whole Pause sequence collapses into one make event
                        w_emit       = 1'b1;
                        w_code       = PS2_PAUSE;
                        w_skip_next  = 3'd0;
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_skip_next  = 3'd0;
                end
            endcase
        end
    end

    // Modifier updates, visible in the same event that caused them
    always_comb begin
        w_lshift_next    = r_lshift;
        w_rshift_next    = r_rshift;
        w_ctrl_next      = r_ctrl;
        w_caps_next      = r_caps;
        w_caps_held_next = r_caps_held;
        if (w_emit) begin
            if (!w_ext && (w_code == PS2_LSHIFT)) begin
                w_lshift_next = !w_released;
            end
            if (!w_ext && (w_code == PS2_RSHIFT)) begin
                w_rshift_next = !w_released;
            end
            // Left and right ctrl share one flag
            if (w_code == PS2_CTRL) begin
                w_ctrl_next = !w_released;
            end
            if (!w_ext && (w_code == PS2_CAPS)) begin
                // Typematic repeats arrive while held and must not toggle
                if (!w_released && !r_caps_held) begin
                    w_caps_next = !r_caps;
                end
                w_caps_held_next = !w_released;
            end
        end
        w_shift_next = w_lshift_next | w_rshift_next;
    end

    // Modifier registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_ctrl      <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else begin
            r_lshift    <= w_lshift_next;
            r_rshift    <= w_rshift_next;
            r_ctrl      <= w_ctrl_next;
            r_caps      <= w_caps_next;
            r_caps_held <= w_caps_held_next;
        end
    end

    ps2_ascii_map u_ascii_map (
        .code  (w_code),
        .ext   (w_ext),
        .shift (w_shift_next),
        .caps  (w_caps_next),
        .ascii (w_ascii)
    );

    assign w_event = ps2_pack_event(w_released, w_ext, w_shift_next, w_ctrl_next,
                                    w_ascii, w_code);

    // ------------------------------------------------------------------
    // Event FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && ev_ready;
    // A pop in the same cycle frees the slot the new event needs
    assign w_push  = w_emit && (!w_full || w_pop);
    assign w_drop  = w_emit && w_full && !w_pop;

    // FIFO storage; contents need no reset as they are gated by ev_valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_event;
        end
    end

    // FIFO pointers and drop indication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_overflow <= w_drop;
        end
    end

    assign ev_valid  = !w_empty;
    assign ev_data   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign overflow  = r_overflow;
    assign caps_lock = r_caps;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_decoder
//  Description : Self-checking bench for ps2_key_decoder with a sequence-level
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    typedef logic [7:0] u8;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  scancode = 8'h00;
    logic        new_code = 1'b0;
    logic [19:0] ev_data;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic        overflow;
    logic        caps_lock;

    ps2_key_decoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .scancode  (scancode),
        .new_code  (new_code),
        .ev_data   (ev_data),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .overflow  (overflow),
        .caps_lock (caps_lock)
    );

    always #5 clk = ~clk;

    // Translation tables, in a..z and 0..9 order
    u8 letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                             8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                             8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                             8'h35, 8'h1A};
    u8 digit_codes  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                             8'h3E, 8'h46};
    u8 digit_syms   [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                             8'h2A, 8'h28};
    u8 status_bytes [6]  = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    u8 special_codes[4]  = '{8'h29, 8'h5A, 8'h66, 8'h76};

    // Reference model state
    u8           pend [$];      // prefix bytes seen so far for the current key
    logic [19:0] q [$];         // expected FIFO contents, head first
    bit          m_lshift, m_rshift, m_ctrl, m_caps, m_caps_down;
    bit          exp_ovf;

    int checks    = 0;
    int failures  = 0;
    int ovf_seen  = 0;
    int pops_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic u8 model_ascii(input u8 code, input bit ext, input bit sh, input bit cp);
        if (ext) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (code == letter_codes[i]) return ((sh ^ cp) ? 8'h41 : 8'h61) + u8'(i);
        for (int i = 0; i < 10; i++)
            if (code == digit_codes[i]) return sh ? digit_syms[i] : 8'h30 + u8'(i);
        case (code)
            8'h29:   return 8'h20;
            8'h5A:   return 8'h0D;
            8'h66:   return 8'h08;
            8'h76:   return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit pend_has(input u8 b);
        foreach (pend[i]) if (pend[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_status(input u8 b);
        foreach (status_bytes[i]) if (status_bytes[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        pend.delete();
        q.delete();
        m_lshift = 0; m_rshift = 0; m_ctrl = 0; m_caps = 0; m_caps_down = 0;
        exp_ovf = 0;
    endtask

    // Advance the model across one clock edge with the given inputs
    task automatic model_edge(input bit nc, input u8 b, input bit rdy);
        bit emit = 0, rel = 0, ext = 0, pop;
        u8  code = b;
        logic [19:0] ev;
        if (nc) begin
            if (pend.size() != 0 && pend[0] == 8'hE1) begin
                pend.push_back(b);
                if (pend.size() == 8) begin
                    emit = 1; code = 8'hE1; pend.delete();
                end
            end else begin
                bit has_e0 = pend_has(8'hE0);
                bit has_f0 = pend_has(8'hF0);
                if (b == 8'hE0) begin
                    if (has_e0 && has_f0) pend.delete();
                    else pend = '{8'hE0};
                end else if (b == 8'hF0) begin
                    if (has_e0 && has_f0) pend.delete();
                    else if (has_e0) pend = '{8'hE0, 8'hF0};
                    else pend = '{8'hF0};
                end else if (pend.size() == 0 && b == 8'hE1) begin
                    pend = '{8'hE1};
                end else if (pend.size() == 0 && is_status(b)) begin
                    // status byte: no event
                end else begin
                    emit = 1; ext = has_e0; rel = has_f0; pend.delete();
                end
            end
        end
        if (emit) begin
            if (!ext && code == 8'h12) m_lshift = !rel;
            if (!ext && code == 8'h59) m_rshift = !rel;
            if (code == 8'h14) m_ctrl = !rel;
            if (!ext && code == 8'h58) begin
                if (!rel && !m_caps_down) m_caps = !m_caps;
                m_caps_down = !rel;
            end
        end
        ev = {rel, ext, (m_lshift | m_rshift), m_ctrl,
              model_ascii(code, ext, m_lshift | m_rshift, m_caps), code};
        pop = (q.size() != 0) && rdy;
        exp_ovf = 0;
        if (emit && q.size() == DEPTH && !pop) exp_ovf = 1;
        if (pop) void'(q.pop_front());
        if (emit && !exp_ovf) q.push_back(ev);
    endtask

    // Compare every observable output against the model
    task automatic compare();
        chk("ev_valid", {31'b0, ev_valid}, {31'b0, q.size() != 0});
        chk("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
        chk("caps_lock", {31'b0, caps_lock}, {31'b0, m_caps});
        if (q.size() != 0) chk("ev_data", {12'b0, ev_data}, {12'b0, q[0]});
        else               chk("ev_data_idle", {12'b0, ev_data}, 32'h0);
        if (overflow) ovf_seen++;
    endtask

    task automatic step(input bit nc, input u8 b, input bit rdy);
        @(negedge clk);
        compare();
        new_code = nc;
        scancode = b;
        ev_ready = rdy;
        if (ev_valid && rdy) pops_seen++;
        model_edge(nc, b, rdy);
    endtask

    task automatic send(input u8 b, input bit rdy);
        step(1'b1, b, rdy);
        repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, rdy);
    endtask

    task automatic drain(output int n);
        int base = pops_seen;
        for (int k = 0; k < 3 * DEPTH && q.size() != 0; k++) step(1'b0, 8'h00, 1'b1);
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        step(1'b0, 8'h00, 1'b0);
        n = pops_seen - base;
    endtask

    task automatic do_reset();
        @(negedge clk);
        compare();
        rst = 1'b1;
        new_code = 1'b0;
        ev_ready = 1'b0;
        model_reset();
        @(negedge clk);
        compare();
        rst = 1'b0;
    endtask

    function automatic u8 rand_byte();
        int r = $urandom_range(0, 99);
        if (r < 8)  return 8'hE0;
        if (r < 16) return 8'hF0;
        if (r < 18) return 8'hE1;
        if (r < 24) return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        if (r < 28) return 8'h14;
        if (r < 32) return 8'h58;
        if (r < 60) return letter_codes[$urandom_range(0, 25)];
        if (r < 75) return digit_codes[$urandom_range(0, 9)];
        if (r < 80) return special_codes[$urandom_range(0, 3)];
        if (r < 84) return status_bytes[$urandom_range(0, 5)];
        return u8'($urandom_range(0, 255));
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int ovf_base;
        model_reset();
        do_reset();

        // Reset state
        chk("reset_valid", {31'b0, ev_valid}, 0);
        chk("reset_data", {12'b0, ev_data}, 0);
        chk("reset_ovf", {31'b0, overflow}, 0);
        chk("reset_caps", {31'b0, caps_lock}, 0);

        // Power-up status byte produces nothing
        step(1'b1, 8'hAA, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("aa_no_event", {31'b0, ev_valid}, 0);

        // Make and break of 'a'
        step(1'b1, 8'h1C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("make_a", {12'b0, ev_data}, 32'h0611C);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("break_a", {12'b0, ev_data}, 32'h8611C);
        drain(n);

        // Shift, caps lock and typematic caps repeat
        send(8'h12, 1'b0);
        send(8'h1C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("lshift_make", {12'b0, ev_data}, 32'h20012);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("shift_a", {12'b0, ev_data}, 32'h2411C);
        drain(n);
        send(8'hF0, 1'b1);
        send(8'h12, 1'b1);
        send(8'h58, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("caps_first", {31'b0, caps_lock}, 1);
        send(8'h58, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("caps_repeat", {31'b0, caps_lock}, 1);
        send(8'hF0, 1'b1);
        send(8'h58, 1'b1);
        drain(n);
        send(8'h1C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("caps_a", {12'b0, ev_data}, 32'h0411C);
        drain(n);

        // Extended make and break
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("ext_make", {12'b0, ev_data}, 32'h40075);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("ext_break", {12'b0, ev_data}, 32'hC0075);
        drain(n);

        // Pause sequence collapses into one event
        send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
        send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0); send(8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("pause_event", {12'b0, ev_data}, 32'h000E1);
        send(8'h1C, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("after_pause", {12'b0, ev_data}, 32'h0411C);
        drain(n);
        chk("pause_count", n, 1);

        // Overflow on a full FIFO, then simultaneous write and pop
        ovf_base = ovf_seen;
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, letter_codes[i], 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_pulses", ovf_seen - ovf_base, 1);
        step(1'b1, 8'h2B, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("full_pop_no_ovf", {31'b0, overflow}, 0);
        drain(n);
        chk("full_count", n, DEPTH);

        // Reset in the middle of an extended sequence
        send(8'hE0, 1'b1);
        do_reset();
        step(1'b1, 8'h1C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("reset_mid_seq", {12'b0, ev_data}, 32'h0611C);
        drain(n);
        chk("reset_mid_count", n, 1);

        // Random traffic: mostly-ready consumer, then a stalling one
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 2) == 0, rand_byte(), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 4) < 3, rand_byte(), $urandom_range(0, 4) == 0);
        drain(n);
        @(negedge clk);
        compare();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
